// File: rtl/sample_window4_pkg.sv
// Shared constants and state type for the sample window stage and the downstream averager.
package sample_window4_pkg;

  localparam int SAMPLE_W     = 16;
  localparam int WINDOW_DEPTH = 4;

  typedef enum logic {
    FILL = 1'b0,
    FULL = 1'b1
  } state_t;

endpackage

// File: rtl/sample_window4_shift4.sv
// Four-stage W-bit shift register with enable; a is the oldest stage, d the newest.
module sample_shift4 #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] din,
  output logic [W-1:0] a,
  output logic [W-1:0] b,
  output logic [W-1:0] c,
  output logic [W-1:0] d
);

  logic [W-1:0] a_r, b_r, c_r, d_r;

  // window storage: shift towards a on every enabled cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_r <= {W{1'b0}};
      b_r <= {W{1'b0}};
      c_r <= {W{1'b0}};
      d_r <= {W{1'b0}};
    end else if (en) begin
      a_r <= b_r;
      b_r <= c_r;
      c_r <= d_r;
      d_r <= din;
    end else begin
      a_r <= a_r;
      b_r <= b_r;
      c_r <= c_r;
      d_r <= d_r;
    end
  end

  assign a = a_r;
  assign b = b_r;
  assign c = c_r;
  assign d = d_r;

endmodule

// File: rtl/sample_window4.sv
// Serial-to-parallel 4-sample window with valid/ready on both sides.
// Define SAMPLE_WINDOW_SLIDING_EN for overlapping (sliding) windows; default is disjoint blocks.
module sample_window4
  import sample_window4_pkg::*;
#(
  parameter int W = SAMPLE_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] in_data,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         flush,
  output logic [W-1:0] A,
  output logic [W-1:0] B,
  output logic [W-1:0] C,
  output logic [W-1:0] D,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [2:0]   fill
);

  localparam logic [2:0] FILL_MAX = 3'(WINDOW_DEPTH);

  state_t     state_r, state_n;
  logic [2:0] fill_r, fill_n;
  logic       out_valid_s, in_xfer_s, out_xfer_s, shift_en_s;

  assign out_valid_s = (state_r == FULL);
  assign in_ready    = ~out_valid_s | out_ready;
  assign in_xfer_s   = in_valid & in_ready;
  assign out_xfer_s  = out_valid_s & out_ready;
  // a flushed cycle drops its sample but leaves the held window untouched
  assign shift_en_s  = in_xfer_s & ~flush;

  sample_shift4 #(.W(W)) u_shift (
    .clk (clk),
    .rst (rst),
    .en  (shift_en_s),
    .din (in_data),
    .a   (A),
    .b   (B),
    .c   (C),
    .d   (D)
  );

  // next state and fill count
  always_comb begin
    state_n = state_r;
    fill_n  = fill_r;
    if (flush) begin
      state_n = FILL;
      fill_n  = 3'd0;
    end else begin
      case (state_r)
        FILL: begin
          if (in_xfer_s) begin
            if (fill_r >= (FILL_MAX - 3'd1)) begin
              fill_n  = FILL_MAX;
              state_n = FULL;
            end else begin
              fill_n  = fill_r + 3'd1;
            end
          end else begin
            fill_n = fill_r;
          end
        end
        FULL: begin
          if (out_xfer_s) begin
`ifdef SAMPLE_WINDOW_SLIDING_EN
            fill_n  = FILL_MAX;
            state_n = in_xfer_s ? FULL : FILL;
`else
            fill_n  = in_xfer_s ? 3'd1 : 3'd0;
            state_n = FILL;
`endif
          end else begin
            state_n = FULL;
          end
        end
        default: begin
          state_n = FILL;
          fill_n  = 3'd0;
        end
      endcase
    end
  end

  // state and fill registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= FILL;
      fill_r  <= 3'd0;
    end else begin
      state_r <= state_n;
      fill_r  <= fill_n;
    end
  end

  assign out_valid = out_valid_s;
  assign fill      = fill_r;

endmodule

// File: tb/tb_sample_window4.sv
// Directed, table-driven bench for sample_window4 plus async-reset and sliding-mode sequences.
module tb_sample_window4;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] in_data;
  logic        in_valid, in_ready, flush, out_valid, out_ready;
  logic [15:0] A, B, C, D;
  logic [2:0]  fill;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  sample_window4 dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .flush(flush), .A(A), .B(B), .C(C), .D(D), .out_valid(out_valid),
    .out_ready(out_ready), .fill(fill)
  );

  typedef struct {
    logic        iv;
    logic [15:0] din;
    logic        ordy;
    logic        fl;
    logic        ov;
    logic [2:0]  fill;
    logic        ir;
    logic [15:0] a, b, c, d;
  } vec_t;

  localparam int NV = 37;
  vec_t vecs [NV];

  function automatic vec_t mk(logic iv, logic [15:0] din, logic ordy, logic fl, logic ov,
                              logic [2:0] fl_cnt, logic ir,
                              logic [15:0] a, logic [15:0] b, logic [15:0] c, logic [15:0] d);
    vec_t v;
    v.iv = iv; v.din = din; v.ordy = ordy; v.fl = fl; v.ov = ov;
    v.fill = fl_cnt; v.ir = ir; v.a = a; v.b = b; v.c = c; v.d = d;
    return v;
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s[%0d]: got %h expected %h", name, idx, act, exp);
    end
  endtask

  task automatic chk_state(input int idx, input logic ov, input logic [2:0] f, input logic ir,
                           input logic [15:0] a, input logic [15:0] b,
                           input logic [15:0] c, input logic [15:0] d);
    chk("out_valid", idx, 32'(out_valid), 32'(ov));
    chk("fill", idx, 32'(fill), 32'(f));
    chk("in_ready", idx, 32'(in_ready), 32'(ir));
    chk("A", idx, 32'(A), 32'(a));
    chk("B", idx, 32'(B), 32'(b));
    chk("C", idx, 32'(C), 32'(c));
    chk("D", idx, 32'(D), 32'(d));
  endtask

  task automatic drive(input logic iv, input logic [15:0] din, input logic ordy, input logic fl);
    in_valid = iv; in_data = din; out_ready = ordy; flush = fl;
  endtask

  initial begin
    // inputs for this cycle / state visible before the next rising edge
    vecs[0]  = mk(1'b1, 16'h0001, 1'b1, 1'b0, 1'b0, 3'd0, 1'b1, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
    vecs[1]  = mk(1'b1, 16'h0002, 1'b1, 1'b0, 1'b0, 3'd1, 1'b1, 16'h0000, 16'h0000, 16'h0000, 16'h0001);
    vecs[2]  = mk(1'b1, 16'h0003, 1'b1, 1'b0, 1'b0, 3'd2, 1'b1, 16'h0000, 16'h0000, 16'h0001, 16'h0002);
    vecs[3]  = mk(1'b1, 16'h0004, 1'b1, 1'b0, 1'b0, 3'd3, 1'b1, 16'h0000, 16'h0001, 16'h0002, 16'h0003);
    vecs[4]  = mk(1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 3'd4, 1'b1, 16'h0001, 16'h0002, 16'h0003, 16'h0004);
    vecs[5]  = mk(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 3'd0, 1'b1, 16'h0001, 16'h0002, 16'h0003, 16'h0004);
    // extremes held under back-pressure, fifth sample waits
    vecs[6]  = mk(1'b1, 16'hFFFF, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1, 16'h0001, 16'h0002, 16'h0003, 16'h0004);
    vecs[7]  = mk(1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0, 3'd1, 1'b1, 16'h0002, 16'h0003, 16'h0004, 16'hFFFF);
    vecs[8]  = mk(1'b1, 16'h7FFF, 1'b0, 1'b0, 1'b0, 3'd2, 1'b1, 16'h0003, 16'h0004, 16'hFFFF, 16'hFFFE);
    vecs[9]  = mk(1'b1, 16'h8000, 1'b0, 1'b0, 1'b0, 3'd3, 1'b1, 16'h0004, 16'hFFFF, 16'hFFFE, 16'h7FFF);
    for (int i = 10; i < 15; i++)
      vecs[i] = mk(1'b1, 16'h0055, 1'b0, 1'b0, 1'b1, 3'd4, 1'b0, 16'hFFFF, 16'hFFFE, 16'h7FFF, 16'h8000);
    vecs[15] = mk(1'b1, 16'h0055, 1'b1, 1'b0, 1'b1, 3'd4, 1'b1, 16'hFFFF, 16'hFFFE, 16'h7FFF, 16'h8000);
    vecs[16] = mk(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 3'd1, 1'b1, 16'hFFFE, 16'h7FFF, 16'h8000, 16'h0055);
    vecs[17] = mk(1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 3'd1, 1'b1, 16'hFFFE, 16'h7FFF, 16'h8000, 16'h0055);
    // sustained 10..17, two back-to-back windows
    vecs[18] = mk(1'b1, 16'h000A, 1'b1, 1'b0, 1'b0, 3'd0, 1'b1, 16'hFFFE, 16'h7FFF, 16'h8000, 16'h0055);
    vecs[19] = mk(1'b1, 16'h000B, 1'b1, 1'b0, 1'b0, 3'd1, 1'b1, 16'h7FFF, 16'h8000, 16'h0055, 16'h000A);
    vecs[20] = mk(1'b1, 16'h000C, 1'b1, 1'b0, 1'b0, 3'd2, 1'b1, 16'h8000, 16'h0055, 16'h000A, 16'h000B);
    vecs[21] = mk(1'b1, 16'h000D, 1'b1, 1'b0, 1'b0, 3'd3, 1'b1, 16'h0055, 16'h000A, 16'h000B, 16'h000C);
    vecs[22] = mk(1'b1, 16'h000E, 1'b1, 1'b0, 1'b1, 3'd4, 1'b1, 16'h000A, 16'h000B, 16'h000C, 16'h000D);
    vecs[23] = mk(1'b1, 16'h000F, 1'b1, 1'b0, 1'b0, 3'd1, 1'b1, 16'h000B, 16'h000C, 16'h000D, 16'h000E);
    vecs[24] = mk(1'b1, 16'h0010, 1'b1, 1'b0, 1'b0, 3'd2, 1'b1, 16'h000C, 16'h000D, 16'h000E, 16'h000F);
    vecs[25] = mk(1'b1, 16'h0011, 1'b1, 1'b0, 1'b0, 3'd3, 1'b1, 16'h000D, 16'h000E, 16'h000F, 16'h0010);
    vecs[26] = mk(1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 3'd4, 1'b1, 16'h000E, 16'h000F, 16'h0010, 16'h0011);
    // 5,6 then flush drops 7; then clean window 20..23
    vecs[27] = mk(1'b1, 16'h0005, 1'b1, 1'b0, 1'b0, 3'd0, 1'b1, 16'h000E, 16'h000F, 16'h0010, 16'h0011);
    vecs[28] = mk(1'b1, 16'h0006, 1'b1, 1'b0, 1'b0, 3'd1, 1'b1, 16'h000F, 16'h0010, 16'h0011, 16'h0005);
    vecs[29] = mk(1'b1, 16'h0007, 1'b1, 1'b1, 1'b0, 3'd2, 1'b1, 16'h0010, 16'h0011, 16'h0005, 16'h0006);
    vecs[30] = mk(1'b1, 16'h0014, 1'b1, 1'b0, 1'b0, 3'd0, 1'b1, 16'h0010, 16'h0011, 16'h0005, 16'h0006);
    vecs[31] = mk(1'b1, 16'h0015, 1'b1, 1'b0, 1'b0, 3'd1, 1'b1, 16'h0011, 16'h0005, 16'h0006, 16'h0014);
    vecs[32] = mk(1'b1, 16'h0016, 1'b1, 1'b0, 1'b0, 3'd2, 1'b1, 16'h0005, 16'h0006, 16'h0014, 16'h0015);
    vecs[33] = mk(1'b1, 16'h0017, 1'b0, 1'b0, 1'b0, 3'd3, 1'b1, 16'h0006, 16'h0014, 16'h0015, 16'h0016);
    vecs[34] = mk(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 3'd4, 1'b0, 16'h0014, 16'h0015, 16'h0016, 16'h0017);
    vecs[35] = mk(1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 3'd4, 1'b0, 16'h0014, 16'h0015, 16'h0016, 16'h0017);
    vecs[36] = mk(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 3'd0, 1'b1, 16'h0014, 16'h0015, 16'h0016, 16'h0017);

    rst = 1'b1;
    drive(1'b0, 16'h0000, 1'b1, 1'b0);
    #12;
    chk_state(-1, 1'b0, 3'd0, 1'b1, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
    @(negedge clk);
    rst = 1'b0;

`ifndef SAMPLE_WINDOW_SLIDING_EN
    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      drive(vecs[i].iv, vecs[i].din, vecs[i].ordy, vecs[i].fl);
      #1;
      chk_state(i, vecs[i].ov, vecs[i].fill, vecs[i].ir, vecs[i].a, vecs[i].b, vecs[i].c, vecs[i].d);
    end
`else
    // sliding: 1..6 with out_ready=1 gives one overlapping window per sample after priming
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (k < 6) drive(1'b1, 16'(k + 1), 1'b1, 1'b0);
      else       drive(1'b0, 16'h0000, 1'b1, 1'b0);
      #1;
      case (k)
        4:       chk_state(100 + k, 1'b1, 3'd4, 1'b1, 16'h0001, 16'h0002, 16'h0003, 16'h0004);
        5:       chk_state(100 + k, 1'b1, 3'd4, 1'b1, 16'h0002, 16'h0003, 16'h0004, 16'h0005);
        6:       chk_state(100 + k, 1'b1, 3'd4, 1'b1, 16'h0003, 16'h0004, 16'h0005, 16'h0006);
        7:       chk_state(100 + k, 1'b0, 3'd4, 1'b1, 16'h0003, 16'h0004, 16'h0005, 16'h0006);
        default: chk("fill", 100 + k, 32'(fill), 32'(k));
      endcase
    end
    @(negedge clk);
    drive(1'b0, 16'h0000, 1'b1, 1'b1);
    @(negedge clk);
    drive(1'b0, 16'h0000, 1'b1, 1'b0);
    #1;
    chk_state(110, 1'b0, 3'd0, 1'b1, 16'h0003, 16'h0004, 16'h0005, 16'h0006);
`endif

    // async reset mid-window clears everything without a clock edge
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      drive(1'b1, 16'h0031 + 16'(k), 1'b1, 1'b0);
    end
    @(negedge clk);
    drive(1'b0, 16'h0000, 1'b1, 1'b0);
    #1;
    chk("fill_pre_rst", 200, 32'(fill), 32'd3);
    chk("D_pre_rst", 200, 32'(D), 32'h0033);
    #1;
    rst = 1'b1;
    #1;
    chk_state(201, 1'b0, 3'd0, 1'b1, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    #1;
    chk_state(202, 1'b0, 3'd0, 1'b1, 16'h0000, 16'h0000, 16'h0000, 16'h0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
